// File: rtl/mtm_alu_serializer_if.sv
// Result handshake and serial line bundle for mtm_alu_serializer.
// valid/ready: a result transfers on a rising clk edge where in_valid && in_ready; the source holds C/ctl_in/err_in stable while in_valid is high.
interface mtm_alu_serializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] C;
    logic [7:0]  ctl_in;
    logic        err_in;
    logic        sout;
    logic        busy;

    modport master (
        output in_valid, C, ctl_in, err_in,
        input  in_ready, sout, busy
    );

    modport slave (
        input  in_valid, C, ctl_in, err_in,
        output in_ready, sout, busy
    );
endinterface

// File: rtl/mtm_alu_serializer.sv
// Serialises an ALU result into 11-bit DATA/CMD packets on sout (4 DATA + 1 CMD, or CMD only on error).
// Optional MTM_ALU_SER_IDLE_GAP_EN adds a 2-cycle GAP state after each frame.
module mtm_alu_serializer (
    input  logic                       clk,
    input  logic                       rst,
    mtm_alu_serializer_if.slave        bus,
    output logic [2:0]                 dbg_state
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        TYPE    = 3'd2,
        PAYLOAD = 3'd3,
        STOP    = 3'd4
`ifdef MTM_ALU_SER_IDLE_GAP_EN
        , GAP   = 3'd5
`endif
    } state_t;

    state_t      state;
    logic        sout_q;
    logic [31:0] c_q;
    logic [7:0]  ctl_q;
    logic        err_q;
    logic [2:0]  bit_cnt;
    logic [2:0]  pkt_cnt;
`ifdef MTM_ALU_SER_IDLE_GAP_EN
    logic        gap_cnt;
`endif

    logic [7:0]  cur_byte;
    logic        type_bit;
    logic        last_pkt;

    // Packet index 4 is always the CMD packet; 0..3 walk C from the top byte down.
    always_comb begin
        cur_byte = ctl_q;
        case (pkt_cnt)
            3'd0:    cur_byte = c_q[31:24];
            3'd1:    cur_byte = c_q[23:16];
            3'd2:    cur_byte = c_q[15:8];
            3'd3:    cur_byte = c_q[7:0];
            default: cur_byte = ctl_q;
        endcase
    end

    assign type_bit = (pkt_cnt == 3'd4);
    assign last_pkt = err_q || (pkt_cnt == 3'd4);

    // sout_q is loaded with the bit belonging to the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sout_q  <= 1'b1;
            c_q     <= '0;
            ctl_q   <= '0;
            err_q   <= 1'b0;
            bit_cnt <= '0;
            pkt_cnt <= '0;
`ifdef MTM_ALU_SER_IDLE_GAP_EN
            gap_cnt <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    sout_q <= 1'b1;
                    if (bus.in_valid) begin
                        c_q     <= bus.C;
                        ctl_q   <= bus.ctl_in;
                        err_q   <= bus.err_in;
                        pkt_cnt <= bus.err_in ? 3'd4 : 3'd0;
                        bit_cnt <= '0;
                        state   <= START;
                        sout_q  <= 1'b0;
                    end
                end
                START: begin
                    state  <= TYPE;
                    sout_q <= type_bit;
                end
                TYPE: begin
                    state   <= PAYLOAD;
                    bit_cnt <= 3'd7;
                    sout_q  <= cur_byte[7];
                end
                PAYLOAD: begin
                    if (bit_cnt == 3'd0) begin
                        state  <= STOP;
                        sout_q <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt - 3'd1;
                        sout_q  <= cur_byte[bit_cnt - 3'd1];
                    end
                end
                STOP: begin
                    if (!last_pkt) begin
                        pkt_cnt <= pkt_cnt + 3'd1;
                        state   <= START;
                        sout_q  <= 1'b0;
                    end else begin
`ifdef MTM_ALU_SER_IDLE_GAP_EN
                        state   <= GAP;
                        gap_cnt <= 1'b0;
`else
                        state   <= IDLE;
`endif
                        sout_q  <= 1'b1;
                    end
                end
`ifdef MTM_ALU_SER_IDLE_GAP_EN
                GAP: begin
                    sout_q <= 1'b1;
                    if (gap_cnt) state <= IDLE;
                    else         gap_cnt <= 1'b1;
                end
`endif
                default: begin
                    state  <= IDLE;
                    sout_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.sout     = sout_q;
    assign dbg_state    = state;
endmodule

// File: tb/tb_mtm_alu_serializer.sv
// Self-checking bench for mtm_alu_serializer: driver tasks push expected packets, a sout monitor pops and compares.
`timescale 1ns/1ps
module tb_mtm_alu_serializer;
    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;

    mtm_alu_serializer_if bus ();

    mtm_alu_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

`ifdef MTM_ALU_SER_IDLE_GAP_EN
    localparam int EXP_BUSY  = 57;
    localparam int EXP_FGAP  = 4;
`else
    localparam int EXP_BUSY  = 55;
    localparam int EXP_FGAP  = 2;
`endif

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          failures = 0;
    logic [10:0] exp_q[$];
    int          cyc = 0;
    int          busy_cnt = 0;
    int          pkt_seen = 0;
    int          last_stop_cyc = -1;
    int          last_frame_gap = -1;
    logic        prev_was_cmd = 1'b0;
    logic        in_pkt = 1'b0;
    int          nbits = 0;
    logic [10:0] shreg = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] pkt(input logic t, input logic [7:0] b);
        return {1'b0, t, b, 1'b1};
    endfunction

    // Monitor: frames packets off sout by the falling start bit, independent of DUT state.
    always @(negedge clk) begin
        logic [10:0] e;
        cyc++;
        if (rst) begin
            in_pkt = 1'b0;
            nbits  = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (!in_pkt) begin
                if (bus.sout == 1'b0) begin
                    in_pkt = 1'b1;
                    nbits  = 1;
                    shreg  = '0;
                    if (prev_was_cmd && last_stop_cyc >= 0)
                        last_frame_gap = cyc - last_stop_cyc;
                end
            end else begin
                shreg = {shreg[9:0], bus.sout};
                nbits++;
                if (nbits == 11) begin
                    in_pkt        = 1'b0;
                    pkt_seen++;
                    last_stop_cyc = cyc;
                    prev_was_cmd  = shreg[9];
                    check_eq("pkt_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("pkt_bits", shreg, e);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [31:0] c, input logic [7:0] ctl, input logic err, input bit hold);
        int n = 0;
        bus.C        = c;
        bus.ctl_in   = ctl;
        bus.err_in   = err;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("accept_wait", n < 400, 1);
        @(posedge clk);
        if (err) begin
            exp_q.push_back(pkt(1'b1, ctl));
        end else begin
            exp_q.push_back(pkt(1'b0, c[31:24]));
            exp_q.push_back(pkt(1'b0, c[23:16]));
            exp_q.push_back(pkt(1'b0, c[15:8]));
            exp_q.push_back(pkt(1'b0, c[7:0]));
            exp_q.push_back(pkt(1'b1, ctl));
        end
        @(negedge clk);
        check_eq("latency_start_bit", bus.sout, 0);
        check_eq("latency_busy", bus.busy, 1);
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && !in_pkt && bus.in_ready) && n < 400);
        check_eq({tag, "_done"}, n < 400, 1);
        check_eq({tag, "_idle_sout"}, bus.sout, 1);
        check_eq({tag, "_idle_ready"}, bus.in_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        logic [31:0] rc;
        logic [7:0]  rctl;
        logic        rerr;

        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.C        = 32'h0BAD_F00D;
        bus.ctl_in   = 8'h77;
        bus.err_in   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_sout", bus.sout, 1);
        check_eq("rst_ready", bus.in_ready, 1);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_state_no_accept", dbg_state, 0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Normal frame, busy length
        busy_cnt = 0;
        p0 = pkt_seen;
        send_frame(32'h1234_5678, 8'h2A, 1'b0, 1'b0);
        wait_done("normal");
        check_eq("normal_busy_cycles", busy_cnt, EXP_BUSY);
        check_eq("normal_pkts", pkt_seen - p0, 5);

        // Error frame: CMD only
        busy_cnt = 0;
        p0 = pkt_seen;
        send_frame(32'hFFFF_FFFF, 8'hC9, 1'b1, 1'b0);
        wait_done("err");
        check_eq("err_pkts", pkt_seen - p0, 1);

        // Back-to-back with in_valid held
        last_frame_gap = -1;
        send_frame(32'hA1B2_C3D4, 8'h5E, 1'b0, 1'b1);
        send_frame(32'h0F0F_F0F0, 8'h81, 1'b0, 1'b0);
        wait_done("b2b");
        check_eq("b2b_frame_gap", last_frame_gap, EXP_FGAP);

        // Inputs disturbed and in_valid pulsed mid-frame
        p0 = pkt_seen;
        send_frame(32'hA5A5_5A5A, 8'h3C, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        bus.C        = 32'hDEAD_BEEF;
        bus.ctl_in   = 8'hFF;
        bus.err_in   = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done("midchg");
        repeat (20) @(negedge clk);
        check_eq("midchg_pkts", pkt_seen - p0, 5);
        check_eq("midchg_queue_empty", exp_q.size(), 0);

        // Reset during packet 2 payload
        send_frame(32'h1122_3344, 8'h55, 1'b0, 1'b0);
        repeat (26) @(negedge clk);
        check_eq("midrst_in_payload", dbg_state, 3);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_sout", bus.sout, 1);
        check_eq("midrst_ready", bus.in_ready, 1);
        check_eq("midrst_busy", bus.busy, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_state_idle", dbg_state, 0);
        p0 = pkt_seen;
        send_frame(32'hCAFE_F00D, 8'h81, 1'b0, 1'b0);
        wait_done("after_rst");
        check_eq("after_rst_pkts", pkt_seen - p0, 5);

        // All-zero frame: stop/type bits and no stuck-low line
        send_frame(32'h0000_0000, 8'h00, 1'b0, 1'b0);
        wait_done("zero");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("zero_line_high", bus.sout, 1);
        end

        // Random frames
        for (int i = 0; i < 6; i++) begin
            rc   = $urandom();
            rctl = 8'($urandom_range(0, 255));
            rerr = ($urandom_range(0, 3) == 0);
            send_frame(rc, rctl, rerr, 1'b0);
            wait_done("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mtm_alu_serializer.md
MTM_ALU_SERIALIZER -- requirements
Module: mtm_alu_serializer

Interface
REQ-001 SHALL have port: clk  input  1  single clock for all state; all sequential logic on posedge clk.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  result word present on C/ctl_in/err_in.
REQ-004 SHALL have port: in_ready  output  1  block idle and able to accept a result.
REQ-005 SHALL have port: C  input  32  ALU result word.
REQ-006 SHALL have port: ctl_in  input  8  control/flags byte for the CMD packet.
REQ-007 SHALL have port: err_in  input  1  error frame request: send the CMD packet only.
REQ-008 SHALL have port: sout  output  1  serial line, registered, idle high.
REQ-009 SHALL have port: busy  output  1  high while a frame is on sout.

Function
REQ-010 SHALL use the 11-bit packet format: start bit 0, type bit (0 = DATA, 1 = CMD), 8 payload bits MSB first, stop bit 1.
REQ-011 SHALL accept a result only on a rising edge with in_valid=1 and in_ready=1, capturing C, ctl_in and err_in into internal registers.
REQ-012 SHALL ignore in_valid while in_ready=0; captured values SHALL NOT change mid-frame.
REQ-013 SHALL, for err_in=0, send a normal frame of 55 bits: four DATA packets with C[31:24], C[23:16], C[15:8], C[7:0], then one CMD packet with ctl_in.
REQ-014 SHALL, for err_in=1, send an error frame of 11 bits: one CMD packet with ctl_in; C is not transmitted.
REQ-015 SHALL drive the first start bit on sout in the cycle after the accepting edge (latency 1), with one bit per clock and no gaps between packets.
REQ-016 SHALL implement the FSM states IDLE, START, TYPE, PAYLOAD, STOP, plus GAP only when REQ-026 applies.
REQ-017 SHALL use these transitions: IDLE->START on accept; START->TYPE; TYPE->PAYLOAD; PAYLOAD->STOP after 8 bits (3-bit bit counter 7 down to 0); STOP->START if packets remain, else IDLE (or GAP).
REQ-018 SHALL use a 3-bit packet counter that is 0..4 for a normal frame and 4 only for an error frame; packet index 4 selects type=1 and the ctl payload, indices 0..3 select type=0 and the C bytes.
REQ-019 SHALL drive in_ready = (state==IDLE) and busy = !in_ready.
REQ-020 SHALL hold sout=1 in IDLE and GAP.
REQ-021 SHALL permit back-to-back frames: with in_valid held, the next accept SHALL occur on the edge where the state returns to IDLE, so a new start bit follows the previous stop bit after exactly one idle cycle.

Reset
REQ-022 SHALL, while rst=1, immediately force state=IDLE, sout=1, in_ready=1, busy=0, counters=0 and captured registers=0.
REQ-023 SHALL abort a frame on reset assertion mid-frame with no completion; after deassertion, the first accept starts a fresh frame from packet 0 (or 4 for an error frame).
REQ-024 SHALL NOT accept a frame in the cycle rst is asserted.

Configuration
REQ-025 SHALL provide the macro MTM_ALU_SER_IDLE_GAP_EN.
REQ-026 SHALL, with MTM_ALU_SER_IDLE_GAP_EN defined, make STOP of the last packet go to GAP, hold sout=1 for 2 cycles with in_ready=0, then go to IDLE, giving a minimum 3 idle cycles between frames.
REQ-027 SHALL, without MTM_ALU_SER_IDLE_GAP_EN, omit the GAP state and logic entirely and go STOP->IDLE directly.

Verification
REQ-028 SHALL cover: C=0x12345678, ctl_in=0x2A, err_in=0 -> 55 bits starting 0 0 00010010 1 and ending 0 1 00101010 1; busy high for exactly 55 cycles.
REQ-029 SHALL cover: err_in=1, ctl_in=0xC9, C=0xFFFFFFFF -> exactly 11 bits 0 1 11001001 1, then sout=1 and in_ready=1.
REQ-030 SHALL cover: in_valid held high with two results queued by the bench -> second start bit exactly 1 cycle after the first frame's stop bit (3 cycles with MTM_ALU_SER_IDLE_GAP_EN).
REQ-031 SHALL cover: C or ctl_in changed and in_valid pulsed during a frame -> transmitted bits equal the captured values and no extra frame is sent.
REQ-032 SHALL cover: rst pulsed during packet 2 payload -> sout=1 in the same cycle, in_ready=1; the next frame is sent complete and correct.
REQ-033 SHALL cover: C=0x00000000, ctl_in=0x00 -> every stop bit is 1 and every type bit matches the packet index; no stuck-low line after the frame.
